// File: rtl/conv_encoder_k4.sv
// Rate-1/2 K=4 convolutional encoder with optional zero tail; PUNCT_R23_EN enables rate-2/3 puncturing.
// 1-cycle accept-to-output latency; stalls while out_valid && !out_ready, in_ready follows the output advance.
module conv_encoder_k4 #(
    parameter logic [3:0] G0        = 4'b1101,
    parameter logic [3:0] G1        = 4'b1111,
    parameter bit         TERMINATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic [1:0] out_mask,
    output logic       out_last,
    output logic [2:0] state_o
);

    typedef enum logic {DATA = 1'b0, TAIL = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [2:0] sr, sr_nxt;
    logic [1:0] tail_cnt, tail_cnt_nxt;
    logic       adv, accept, tail_emit, emit, frame_end;
    logic       enc_bit, y0, y1;
    logic [3:0] v;
    logic [1:0] sym_w, mask_w;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = (state == DATA) && adv;
    assign accept    = in_valid && in_ready;
    assign tail_emit = (state == TAIL) && adv;
    assign emit      = accept || tail_emit;
    assign frame_end = (accept && in_last && !TERMINATE) || (tail_emit && tail_cnt == 2'd2);

    // Tail symbols feed a forced zero into the same generator taps.
    assign enc_bit = (state == DATA) && in_bit;
    assign v       = {enc_bit, sr};
    assign y0      = ^(v & G0);
    assign y1      = ^(v & G1);
    assign state_o = sr;

    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        tail_cnt_nxt = tail_cnt;
        if (accept) begin
            sr_nxt = {in_bit, sr[2:1]};
            if (in_last) begin
                if (TERMINATE) begin
                    state_nxt    = TAIL;
                    tail_cnt_nxt = 2'd0;
                end else begin
                    sr_nxt = 3'd0;
                end
            end
        end else if (tail_emit) begin
            sr_nxt = {1'b0, sr[2:1]};
            if (tail_cnt == 2'd2) begin
                state_nxt    = DATA;
                tail_cnt_nxt = 2'd0;
            end else begin
                tail_cnt_nxt = tail_cnt + 2'd1;
            end
        end
    end

`ifdef PUNCT_R23_EN
    logic punct_phase;

    // Pattern [11;10]: odd symbols of a frame carry only y0.
    assign mask_w = punct_phase ? 2'b01 : 2'b11;
    assign sym_w  = punct_phase ? {1'b0, y0} : {y1, y0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            punct_phase <= 1'b0;
        end else if (emit) begin
            punct_phase <= frame_end ? 1'b0 : !punct_phase;
        end
    end
`else
    assign mask_w = 2'b11;
    assign sym_w  = {y1, y0};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DATA;
            sr       <= 3'd0;
            tail_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            tail_cnt <= tail_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sym   <= 2'b00;
            out_mask  <= 2'b00;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= emit;
            if (emit) begin
                out_sym  <= sym_w;
                out_mask <= mask_w;
                out_last <= frame_end;
            end
        end
    end

    // Three zero shifts must flush the trellis back to state 0.
    always_ff @(posedge clk) begin
        if (!rst && tail_emit && tail_cnt == 2'd2) begin
            assert (sr_nxt == 3'd0);
        end
    end

endmodule

// File: tb/tb_conv_encoder_k4.sv
// Bench for conv_encoder_k4: fixed vector tables, hand sequences and randomized frames vs a history-window model.
module tb_conv_encoder_k4;

    localparam logic [3:0] TB_G0 = 4'b1101;
    localparam logic [3:0] TB_G1 = 4'b1111;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid0, in_valid1, in_bit, in_last, out_ready;
    logic       in_ready0, in_ready1;
    logic       out_valid0, out_valid1, out_last0, out_last1;
    logic [1:0] out_sym0, out_sym1, out_mask0, out_mask1;
    logic [2:0] state_o0, state_o1;

    typedef struct {
        logic [1:0] sym;
        logic [1:0] mask;
        logic       last;
        logic [2:0] st;
        int         cyc;
    } rec_t;

    typedef struct {
        bit         drive;
        bit         b;
        bit         l;
        logic [1:0] sym;
        logic [2:0] st;
        bit         last;
    } vec_t;

    rec_t got0[$], got1[$], expq[$];
    int   nchk = 0, nerr = 0, cyc = 0, rdy_mode = 0;

    conv_encoder_k4 #(.G0(TB_G0), .G1(TB_G1), .TERMINATE(1'b1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
        .out_sym(out_sym0), .out_mask(out_mask0), .out_last(out_last0), .state_o(state_o0)
    );

    conv_encoder_k4 #(.G0(TB_G0), .G1(TB_G1), .TERMINATE(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
        .out_sym(out_sym1), .out_mask(out_mask1), .out_last(out_last1), .state_o(state_o1)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    // Collector: records handshaken symbols and checks output stability across stalls.
    initial begin
        bit         pv0 = 0, pv1 = 0;
        logic [5:0] prev0 = '0, prev1 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv0 = 0;
                pv1 = 0;
            end else begin
                if (pv0) check("stall0", {out_valid0, out_sym0, out_mask0, out_last0}, prev0);
                if (pv1) check("stall1", {out_valid1, out_sym1, out_mask1, out_last1}, prev1);
                if (out_valid0 && out_ready) got0.push_back('{out_sym0, out_mask0, out_last0, state_o0, cyc});
                if (out_valid1 && out_ready) got1.push_back('{out_sym1, out_mask1, out_last1, state_o1, cyc});
                pv0   = out_valid0 && !out_ready;
                pv1   = out_valid1 && !out_ready;
                prev0 = {out_valid0, out_sym0, out_mask0, out_last0};
                prev1 = {out_valid1, out_sym1, out_mask1, out_last1};
            end
        end
    end

    // Returns {mask, sym} for symbol number idx of a frame.
    function automatic logic [3:0] pun(input int idx, input logic [1:0] sym);
`ifdef PUNCT_R23_EN
        if (idx % 2 == 1) return {2'b01, 1'b0, sym[0]};
`endif
        return {2'b11, sym};
    endfunction

    // Each output bit is the XOR of the generator-selected bits among the last four inputs.
    task automatic model_frame(input bit bits[$], input bit term);
        bit         h[$];
        bit         b;
        logic       y0, y1;
        logic [3:0] pm;
        int         st;
        h = bits;
        if (term) repeat (3) h.push_back(1'b0);
        for (int i = 0; i < h.size(); i++) begin
            y0 = 1'b0;
            y1 = 1'b0;
            for (int k = 0; k < 4; k++) begin
                b  = (i - k >= 0) ? h[i - k] : 1'b0;
                y0 = y0 ^ (TB_G0[3 - k] & b);
                y1 = y1 ^ (TB_G1[3 - k] & b);
            end
            st = 4 * int'(h[i]) + ((i >= 1) ? 2 * int'(h[i - 1]) : 0) + ((i >= 2) ? int'(h[i - 2]) : 0);
            if (!term && i == h.size() - 1) st = 0;
            pm = pun(i, {y1, y0});
            expq.push_back('{pm[1:0], pm[3:2], (i == h.size() - 1), 3'(st), 0});
        end
    endtask

    task automatic send(input int d, input bit b, input bit l);
        int   n = 0;
        logic r;
        in_bit  = b;
        in_last = l;
        if (d == 0) in_valid0 = 1'b1;
        else        in_valid1 = 1'b1;
        do begin
            @(negedge clk);
            n++;
            r = (d == 0) ? in_ready0 : in_ready1;
        end while (!r && n < 500);
        check("send_ready", r, 1);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_syms(input int d, input int n);
        int c = 0;
        while (((d == 0) ? got0.size() : got1.size()) < n && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic cmp(input int d, input string tag);
        rec_t g;
        int   n;
        n = (d == 0) ? got0.size() : got1.size();
        check({tag, "_count"}, n, expq.size());
        for (int i = 0; i < expq.size() && i < n; i++) begin
            g = (d == 0) ? got0[i] : got1[i];
            check($sformatf("%s_sym[%0d]", tag, i), g.sym, expq[i].sym);
            check($sformatf("%s_mask[%0d]", tag, i), g.mask, expq[i].mask);
            check($sformatf("%s_last[%0d]", tag, i), g.last, expq[i].last);
            check($sformatf("%s_state[%0d]", tag, i), g.st, expq[i].st);
        end
    endtask

    task automatic run_table(input string tag, input vec_t tbl[7], input bit chk_tail);
        logic [3:0] pm;
        int         n = 0;
        got0.delete();
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].drive) send(0, tbl[i].b, tbl[i].l);
        end
        if (chk_tail) begin
            in_valid0 = 1'b1;
            in_bit    = 1'b1;
            in_last   = 1'b0;
            forever begin
                @(negedge clk);
                n++;
                if ((out_valid0 && out_last0) || n > 100) break;
                check("tail_in_ready", in_ready0, 0);
            end
            in_valid0 = 1'b0;
            @(posedge clk);
            #1;
        end
        wait_syms(0, 7);
        check({tag, "_count"}, got0.size(), 7);
        for (int i = 0; i < 7 && i < got0.size(); i++) begin
            pm = pun(i, tbl[i].sym);
            check($sformatf("%s_sym[%0d]", tag, i), got0[i].sym, pm[1:0]);
            check($sformatf("%s_mask[%0d]", tag, i), got0[i].mask, pm[3:2]);
            check($sformatf("%s_last[%0d]", tag, i), got0[i].last, tbl[i].last);
            check($sformatf("%s_state[%0d]", tag, i), got0[i].st, tbl[i].st);
        end
    endtask

    initial begin
        vec_t tbl[7];
        bit   fr[$];
        int   len;

        tbl[0] = '{1, 1, 0, 2'b11, 3'd4, 0};
        tbl[1] = '{1, 0, 0, 2'b11, 3'd2, 0};
        tbl[2] = '{1, 1, 0, 2'b01, 3'd5, 0};
        tbl[3] = '{1, 1, 1, 2'b11, 3'd6, 0};
        tbl[4] = '{0, 0, 0, 2'b01, 3'd3, 0};
        tbl[5] = '{0, 0, 0, 2'b01, 3'd1, 0};
        tbl[6] = '{0, 0, 0, 2'b11, 3'd0, 1};

        rst       = 1'b1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_sym", out_sym0, 0);
        check("rst_out_mask", out_mask0, 0);
        check("rst_out_last", out_last0, 0);
        check("rst_state", state_o0, 0);
        check("rst_in_ready", in_ready0, 1);
        check("rst_state_t0", state_o1, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_table("frame4", tbl, 1'b0);

        rdy_mode = 1;
        run_table("frame4_toggle", tbl, 1'b1);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // 1-bit frame immediately followed by a 2-bit frame.
        got0.delete();
        expq.delete();
        fr.delete(); fr.push_back(1'b1);
        model_frame(fr, 1'b1);
        fr.delete(); fr.push_back(1'b0); fr.push_back(1'b1);
        model_frame(fr, 1'b1);
        send(0, 1'b1, 1'b1);
        send(0, 1'b0, 1'b0);
        send(0, 1'b1, 1'b1);
        wait_syms(0, 9);
        cmp(0, "b2b");
        for (int i = 1; i < 9 && i < got0.size(); i++)
            check($sformatf("b2b_gap[%0d]", i), got0[i].cyc - got0[i - 1].cyc, 1);

        // No-tail variant.
        got1.delete();
        expq.delete();
        fr.delete(); fr.push_back(1'b1); fr.push_back(1'b1);
        model_frame(fr, 1'b0);
        send(1, 1'b1, 1'b0);
        send(1, 1'b1, 1'b1);
        wait_syms(1, 2);
        cmp(1, "term0");
        @(negedge clk);
        check("term0_state_after", state_o1, 0);
        @(posedge clk);
        #1;

        // Reset while the second tail symbol is presented.
        got0.delete();
        send(0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid0, 1);
        rst = 1'b1;
        #1;
        check("midtail_rst_valid", out_valid0, 0);
        check("midtail_rst_state", state_o0, 0);
        check("midtail_rst_last", out_last0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        got0.delete();
        expq.delete();
        fr.delete(); fr.push_back(1'b1);
        model_frame(fr, 1'b1);
        send(0, 1'b1, 1'b1);
        wait_syms(0, 4);
        cmp(0, "rst_retry");

        // Randomized frames with random backpressure and input gaps.
        rdy_mode = 2;
        for (int d = 0; d < 2; d++) begin
            got0.delete();
            got1.delete();
            expq.delete();
            for (int f = 0; f < 10; f++) begin
                len = $urandom_range(1, 8);
                fr.delete();
                for (int j = 0; j < len; j++) fr.push_back(1'($urandom_range(0, 1)));
                model_frame(fr, (d == 0));
                for (int j = 0; j < len; j++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(d, fr[j], (j == len - 1));
                end
            end
            wait_syms(d, expq.size());
            cmp(d, (d == 0) ? "rand_tail" : "rand_notail");
        end
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
